// File: rtl/n2r_stream_buffer.sv
// Row-major matrix to per-core BLOCK_SIZE x BLOCK_SIZE tile reshaper with valid/ready on both sides.
// Define N2R_PINGPONG_EN for two ping-pong banks; leave it undefined for a single bank.
module n2r_stream_buffer #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int NUM_CORES  = 4,
    parameter int COL        = 8,
    parameter int ROW        = 12,
    localparam int CHUNK_SIZE = BLOCK_SIZE * BLOCK_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH*COL-1:0]                  in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_data,
    output logic                                  out_last,
    output logic                                  group_done
);
    localparam int R    = BLOCK_SIZE * NUM_CORES;
    localparam int NB   = COL / BLOCK_SIZE;
    localparam int FW   = (R > 1) ? $clog2(R) : 1;
    localparam int ROWW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int OW   = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int TW   = WIDTH * CHUNK_SIZE;
`ifdef N2R_PINGPONG_EN
    localparam logic PINGPONG = 1'b1;
`else
    localparam logic PINGPONG = 1'b0;
`endif

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_e;

    bank_state_e            state_q [2];
    bank_state_e            state_d [2];
    logic [WIDTH*COL-1:0]   rows_q [2][R];
    logic [1:0]             last_q;
    logic                   fill_bank_q, fill_bank_d;
    logic                   ld_bank_q, ld_bank_d;
    logic                   out_bank_q;
    logic [FW-1:0]          fill_cnt_q, fill_cnt_d;
    logic [ROWW-1:0]        row_cnt_q, row_cnt_d;
    logic [BW-1:0]          ld_beat_q, ld_beat_d;
    logic                   out_valid_q, out_last_q, out_gend_q, group_done_q;
    logic [OW-1:0]          out_data_q;
    logic [OW-1:0]          tile;
    logic                   wr, close, frame_end, accept_last, ld_start, ld_end, load;

    always_comb begin
        frame_end   = (row_cnt_q == ROWW'(ROW - 1));
        accept_last = out_valid_q & out_ready & out_gend_q;
        // A bank whose final beat is leaving this cycle can take a row immediately.
        in_ready    = (state_q[fill_bank_q] == B_EMPTY) || (state_q[fill_bank_q] == B_FILLING)
                      || (accept_last && (out_bank_q == fill_bank_q));
        wr          = in_valid & in_ready;
        close       = wr & ((fill_cnt_q == FW'(R - 1)) | frame_end);
        ld_start    = (ld_beat_q == '0);
        ld_end      = (ld_beat_q == BW'(NB - 1));
        load        = (!out_valid_q | out_ready) &
                      (ld_start ? (state_q[ld_bank_q] == B_FULL) : 1'b1);

        fill_cnt_d  = fill_cnt_q;
        row_cnt_d   = row_cnt_q;
        fill_bank_d = fill_bank_q;
        ld_beat_d   = ld_beat_q;
        ld_bank_d   = ld_bank_q;
        if (wr) begin
            fill_cnt_d = close ? '0 : fill_cnt_q + FW'(1);
            row_cnt_d  = frame_end ? '0 : row_cnt_q + ROWW'(1);
            if (close) fill_bank_d = fill_bank_q ^ PINGPONG;
        end
        if (load) begin
            ld_beat_d = ld_end ? '0 : ld_beat_q + BW'(1);
            if (ld_end) ld_bank_d = ld_bank_q ^ PINGPONG;
        end

        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (accept_last && (out_bank_q == 1'(b))) state_d[b] = B_EMPTY;
            if (load && ld_start && (ld_bank_q == 1'(b))) state_d[b] = B_DRAINING;
            if (wr && (fill_bank_q == 1'(b))) state_d[b] = close ? B_FULL : B_FILLING;
        end
    end

    // Each core's tile: element (r,k) at slot B*B-1-(r*B+k), core 0 in the top slice.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        logic [TW-1:0] core_tile;
        always_comb begin
            core_tile = '0;
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                for (int k = 0; k < BLOCK_SIZE; k++) begin
                    core_tile[(CHUNK_SIZE - 1 - (r * BLOCK_SIZE + k)) * WIDTH +: WIDTH] =
                        rows_q[ld_bank_q][gi * BLOCK_SIZE + r]
                              [(COL - 1 - (int'(ld_beat_q) * BLOCK_SIZE + k)) * WIDTH +: WIDTH];
                end
            end
        end
        assign tile[(NUM_CORES - 1 - gi) * TW +: TW] = core_tile;
    end

    // Closing a group early zeroes the rows it never received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < R; r++)
                    rows_q[b][r] <= '0;
        end else if (wr) begin
            for (int r = 0; r < R; r++) begin
                if (r == int'(fill_cnt_q))
                    rows_q[fill_bank_q][r] <= in_data;
                else if (close && (r > int'(fill_cnt_q)))
                    rows_q[fill_bank_q][r] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) state_q[b] <= B_EMPTY;
            last_q       <= '0;
            fill_bank_q  <= 1'b0;
            ld_bank_q    <= 1'b0;
            out_bank_q   <= 1'b0;
            fill_cnt_q   <= '0;
            row_cnt_q    <= '0;
            ld_beat_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_gend_q   <= 1'b0;
            group_done_q <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) state_q[b] <= state_d[b];
            fill_bank_q  <= fill_bank_d;
            ld_bank_q    <= ld_bank_d;
            fill_cnt_q   <= fill_cnt_d;
            row_cnt_q    <= row_cnt_d;
            ld_beat_q    <= ld_beat_d;
            group_done_q <= accept_last;
            if (close) last_q[fill_bank_q] <= frame_end;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= tile;
                out_last_q  <= last_q[ld_bank_q] & ld_end;
                out_gend_q  <= ld_end;
                out_bank_q  <= ld_bank_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign group_done = group_done_q;
endmodule

// File: tb/tb_n2r_stream_buffer.sv
// Scoreboard bench for n2r_stream_buffer: a matrix-level model predicts tiles, a monitor checks beats.
module tb_n2r_stream_buffer;
    localparam int W    = 16;
    localparam int B    = 2;
    localparam int NC   = 2;
    localparam int C    = 4;
    localparam int NR   = 6;
    localparam int R    = B * NC;
    localparam int NB   = C / B;
    localparam int OW   = W * B * B * NC;
    localparam int RWID = W * C;

    logic            clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last, group_done;
    logic [RWID-1:0] in_data;
    logic [OW-1:0]   out_data;

    typedef struct {
        logic [OW-1:0] data;
        bit            last;
        bit            gend;
    } exp_t;

    exp_t            exp_q[$];
    logic [RWID-1:0] m_grp [R];
    int              m_fill, m_frow;
    int              npass = 0;
    int              ntotal = 0;
    int              nbeat = 0;
    bit              ready_mode = 0;

    logic [OW-1:0] beat0_c = 128'h0000_0001_0010_0011_0020_0021_0030_0031;
    logic [OW-1:0] beat1_c = 128'h0002_0003_0012_0013_0022_0023_0032_0033;

    n2r_stream_buffer #(
        .WIDTH(W), .BLOCK_SIZE(B), .NUM_CORES(NC), .COL(C), .ROW(NR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .group_done(group_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void reset_model();
        exp_q.delete();
        m_fill = 0;
        m_frow = 0;
        for (int i = 0; i < R; i++) m_grp[i] = '0;
    endfunction

    // Matrix-level model: collect a row group, then cut it into tiles once the group closes.
    function automatic void model_accept(input logic [RWID-1:0] row);
        bit            fend, cl;
        exp_t          e;
        logic [OW-1:0] beat;
        logic [RWID-1:0] rr;
        logic [W-1:0]  el;
        m_grp[m_fill] = row;
        fend = (m_frow == NR - 1);
        cl   = fend || (m_fill == R - 1);
        if (cl) begin
            for (int j = 0; j < NB; j++) begin
                beat = '0;
                for (int c = 0; c < NC; c++)
                    for (int r = 0; r < B; r++)
                        for (int k = 0; k < B; k++) begin
                            rr   = m_grp[c * B + r];
                            el   = rr[(C - 1 - (j * B + k)) * W +: W];
                            beat = {beat[OW-W-1:0], el};
                        end
                e.data = beat;
                e.last = fend && (j == NB - 1);
                e.gend = (j == NB - 1);
                exp_q.push_back(e);
            end
            for (int i = 0; i < R; i++) m_grp[i] = '0;
            m_fill = 0;
        end else begin
            m_fill++;
        end
        m_frow = fend ? 0 : m_frow + 1;
    endfunction

    function automatic logic [RWID-1:0] make_row(input bit rnd);
        logic [RWID-1:0] row;
        row = '0;
        for (int k = 0; k < C; k++)
            row[(C - 1 - k) * W +: W] = rnd ? W'($urandom) : W'(m_frow * 16 + k);
        return row;
    endfunction

    task automatic send_rows(input int n, input bit rnd_v, input bit rnd_d, output int lows);
        int sent = 0;
        int guard = 0;
        lows = 0;
        while (sent < n && guard < 4000) begin
            in_valid = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = make_row(rnd_d);
            @(negedge clk);
            if (in_valid && !in_ready) lows++;
            if (in_valid && in_ready) begin
                $display("row  frame_row=%0d data=%h", m_frow, in_data);
                model_accept(in_data);
                sent++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (sent < n) begin
            ntotal++;
            $display("FAIL send_rows: accepted %0d rows, required %0d", sent, n);
        end
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        chk("drain_done", ok, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic scenario1();
        int lows;
        send_rows(4, 0, 0, lows);
        chk("lat_pre_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", out_valid, 1);
        chk("g0_beat0", out_data, beat0_c);
        chk("g0_beat0_last", out_last, 0);
        @(posedge clk);
        #1;
        chk("g0_beat1_valid", out_valid, 1);
        chk("g0_beat1", out_data, beat1_c);
        send_rows(2, 0, 0, lows);
        wait_drain();
    endtask

    // Output monitor: scoreboard pop on transfer, hold stability under stall, group_done timing.
    initial begin : monitor
        bit            gd_pend = 0;
        bit            hold_v = 0;
        logic [OW-1:0] hold_d = '0;
        bit            hold_l = 0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gd_pend = 0;
                hold_v  = 0;
                continue;
            end
            chk("group_done", group_done, gd_pend);
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_d);
                chk("hold_last", out_last, hold_l);
            end
            gd_pend = 0;
            if (out_valid && out_ready) begin
                $display("beat %0d data=%h last=%b", nbeat, out_data, out_last);
                nbeat++;
                if (exp_q.size() == 0) begin
                    ntotal++;
                    $display("FAIL unexpected_beat: got %h, required no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", out_last, e.last);
                    gd_pend = e.gend;
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : main
        int lows;
        int exp_lows;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_group_done", group_done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Group 0 layout and latency, then padded group 1 with frame end
        scenario1();

        // Back-to-back frames with continuous input
        send_rows(3 * NR, 0, 0, lows);
`ifdef N2R_PINGPONG_EN
        exp_lows = 0;
`else
        exp_lows = 2 * (3 * 2 - 1);
`endif
        chk("in_ready_low_cycles", lows, exp_lows);
        wait_drain();

        // Randomised traffic on both sides
        ready_mode = 1;
        send_rows(33 * NR, 1, 1, lows);
        ready_mode = 0;
        out_ready  = 1'b1;
        wait_drain();

        // Backpressure on beat 0
        out_ready = 1'b0;
        send_rows(4, 0, 0, lows);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid", out_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_beat0", out_data, beat0_c);
        out_ready = 1'b1;
        send_rows(2, 0, 0, lows);
        wait_drain();

        // Asynchronous reset after row 2 of a frame, then a fresh frame
        send_rows(3, 0, 0, lows);
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_group_done", group_done, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        scenario1();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/n2r_stream_buffer.md
# n2r_stream_buffer

Parametrised normal-to-ready reshaper with valid/ready handshakes on both sides. It accepts a row-major matrix one row per beat and emits, per output beat, one BLOCK_SIZE×BLOCK_SIZE tile for each of NUM_CORES matrix-multiply cores. It sits between the row-streaming producer and the multi-MAC core array. It supersedes the single-bank n2r buffer by adding:
- backpressure;
- ping-pong banking;
- zero-padding of a partial final row group;
- frame-end marking.

## Interface
- WIDTH, 16, element width in bits
- BLOCK_SIZE, 2, tile edge B; COL must be a multiple of B
- NUM_CORES, 4, tiles per output beat; row group R = B*NUM_CORES
- COL, 8, matrix columns; elements per input row
- ROW, 12, matrix rows per frame; any value ≥1
- CHUNK_SIZE, BLOCK_SIZE*BLOCK_SIZE, elements per tile (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input row valid
- in_ready  out  1  buffer can accept a row
- in_data  in  WIDTH*COL  one row; column k at bits [(COL-1-k)*WIDTH +: WIDTH] (column 0 at MSB)
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  WIDTH*CHUNK_SIZE*NUM_CORES  NUM_CORES tiles
- out_last  out  1  high with the final beat of a frame
- group_done  out  1  one-cycle pulse after the last beat of a row group is accepted

## Operation
- Row group g covers rows g*R .. g*R+R-1.
- Groups per frame G = ceil(ROW/R). Beats per group = COL/B.
- Rows beyond ROW-1 in the last group are zero.
- The fill side writes accepted rows (in_valid & in_ready) into the current bank at row index fill_cnt.
  - When fill_cnt reaches R-1, or the frame row count reaches ROW-1, the bank is marked FULL.
  - A bank closed early has its unwritten rows cleared to 0.
- Each bank follows EMPTY -> FILLING (first row written) -> FULL (group closed) -> DRAINING (first beat loaded to output) -> EMPTY (last beat accepted).
- Output beat j (0..COL/B-1), core c (0..NUM_CORES-1):
  - The tile covers rows c*B..c*B+B-1 and columns j*B..j*B+B-1.
  - Core 0 occupies the most-significant CHUNK_SIZE*WIDTH slice.
  - Within a tile, element (r,k) sits at slot B*B-1-(r*B+k), MSB-first row-major.
- Drain order is j = 0 .. COL/B-1. Banks drain in the order they were filled.
- out_last = 1 on beat j = COL/B-1 of group G-1 only.
- After frame end, row and group counters wrap to 0. The next frame streams without gaps.
- in_ready = 1 whenever the fill bank is EMPTY or FILLING.
- Reset mid-operation clears all banks to EMPTY and all counters to 0. Partial data is discarded, not drained.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, group_done = 0.
  - Counters 0, both banks EMPTY.
- out_data and out_valid are registered.
  - First beat: out_valid rises the cycle after the row that closes the group is accepted (latency 1).
  - If the other bank is still draining, the first beat follows its last accepted beat with no idle cycle.
- Handshake:
  - While out_valid & !out_ready, out_data and out_last hold stable.
  - A beat transfers on out_valid & out_ready. The next beat is presented the following cycle.
- group_done pulses the cycle after the last beat of a group transfers.
- Same-cycle fill-close and drain-complete: the freed bank becomes the new fill bank that cycle, and in_ready does not drop.
- With both banks FULL/DRAINING, in_ready = 0 until one returns to EMPTY.
- in_data is ignored when in_ready = 0.

## Configuration
- N2R_PINGPONG_EN defined:
  - Two banks.
  - Filling overlaps draining, so there is sustained one row/cycle input when COL/B ≤ R and out_ready is held high.
- N2R_PINGPONG_EN undefined:
  - Single bank.
  - in_ready = 0 from group close until the last beat of that group is accepted.
  - Output format, latency and out_last are unchanged.

## Test plan
Common setup: WIDTH=16, B=2, NUM_CORES=2, COL=4, ROW=6, so R=4, 2 beats/group, G=2. Element (r,k) = r*16+k.

1. Group 0, out_ready = 1:
   - Beat 0 = {0x0000,0x0001,0x0010,0x0011,0x0020,0x0021,0x0030,0x0031}.
   - Beat 1 = {0x0002,0x0003,0x0012,0x0013,0x0022,0x0023,0x0032,0x0033}.
   - out_valid rises 1 cycle after row 3 is accepted.
2. Padding and frame end:
   - Group 1 beat 0 = {0x0040,0x0041,0x0050,0x0051,0,0,0,0}.
   - Beat 1 carries out_last = 1.
   - group_done pulses after each group.
3. Backpressure: hold out_ready = 0 for 5 cycles during beat 0 -> out_data stable, no beat skipped or repeated.
4. Back-to-back frames with N2R_PINGPONG_EN, in_valid = 1 throughout -> in_ready never drops; 4 output beats per frame, in order.
5. Same stream without N2R_PINGPONG_EN -> in_ready low exactly 2 cycles per group; output identical to scenario 4.
6. Assert rst_n asynchronously after row 2 of a frame -> outputs go to reset values immediately; a fresh frame then reproduces scenario 1 exactly.
